// File: rtl/timing_strobe_gen.sv
// Multi-channel programmable strobe generator: one single-cycle strobe per channel every P cycles.
// Optional one-shot mode is compiled in with `define TIMING_STROBE_ONESHOT_EN.
module timing_strobe_gen #(
    parameter int CHANNELS          = 4,
    parameter int CNT_WIDTH         = 16,
    parameter int DEFAULT_PERIOD_NS = 1000,
    parameter int SYS_CLOCK_MHZ     = 64
) (
    input  logic                                       clock_i,
    input  logic                                       reset_i,
    input  logic [CHANNELS-1:0]                        enable_i,
    input  logic                                       sync_i,
    input  logic                                       wr_en_i,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] wr_chan_i,
    input  logic [CNT_WIDTH-1:0]                       wr_period_i,
`ifdef TIMING_STROBE_ONESHOT_EN
    input  logic [CHANNELS-1:0]                        oneshot_i,
`endif
    output logic [CHANNELS-1:0]                        strobe_o
);

    // Same rounding as common_pkg::ns_to_cycles (nearest cycle at SYS_CLOCK_MHZ).
    function automatic longint ns_to_cycles(input longint ns);
        return (ns * SYS_CLOCK_MHZ + 500) / 1000;
    endfunction

    localparam longint DEFAULT_CYCLES_L = ns_to_cycles(DEFAULT_PERIOD_NS);
    localparam longint CNT_MAX_L        = (longint'(1) << CNT_WIDTH) - 1;

    if (DEFAULT_CYCLES_L == 0 || DEFAULT_CYCLES_L > CNT_MAX_L) begin : g_bad_default
        $error("timing_strobe_gen: DEFAULT_CYCLES out of range for CNT_WIDTH");
    end
    if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
        $error("timing_strobe_gen: CHANNELS must be 1..16");
    end

    localparam logic [CNT_WIDTH-1:0] DEFAULT_CYCLES = CNT_WIDTH'(DEFAULT_CYCLES_L);
    localparam logic [CNT_WIDTH-1:0] DEFAULT_RELOAD = DEFAULT_CYCLES - 1'b1;

    logic [CNT_WIDTH-1:0] period_q [CHANNELS];
    logic [CNT_WIDTH-1:0] period_d [CHANNELS];
    logic [CNT_WIDTH-1:0] count_q  [CHANNELS];
    logic [CNT_WIDTH-1:0] count_d  [CHANNELS];
    logic [CNT_WIDTH-1:0] reload   [CHANNELS];
    logic [CHANNELS-1:0]  strobe_q;
    logic [CHANNELS-1:0]  strobe_d;
    logic [CHANNELS-1:0]  wr_hit;
    logic [CNT_WIDTH-1:0] wr_reload;
`ifdef TIMING_STROBE_ONESHOT_EN
    logic [CHANNELS-1:0]  armed_q;
    logic [CHANNELS-1:0]  armed_d;
`endif

    // A zero period parks the counter at 0 instead of wrapping to all ones.
    assign wr_reload = (wr_period_i == '0) ? '0 : wr_period_i - 1'b1;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_hit[i] = wr_en_i && (int'(wr_chan_i) == i);
            reload[i] = (period_q[i] == '0) ? '0 : period_q[i] - 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            period_d[i] = period_q[i];
            count_d[i]  = count_q[i];
            strobe_d[i] = 1'b0;
`ifdef TIMING_STROBE_ONESHOT_EN
            armed_d[i]  = armed_q[i];
`endif
            if (wr_hit[i]) begin
                period_d[i] = wr_period_i;
                count_d[i]  = wr_reload;
`ifdef TIMING_STROBE_ONESHOT_EN
                armed_d[i]  = 1'b1;
`endif
            end else if (sync_i || !enable_i[i]) begin
                count_d[i]  = reload[i];
`ifdef TIMING_STROBE_ONESHOT_EN
                armed_d[i]  = 1'b1;
`endif
            end else if (period_q[i] == '0) begin
                count_d[i]  = '0;
`ifdef TIMING_STROBE_ONESHOT_EN
            end else if (!armed_q[i]) begin
                // Disarmed channels sit at 0 until one-shot mode is released.
                if (!oneshot_i[i]) begin
                    armed_d[i] = 1'b1;
                    count_d[i] = reload[i];
                end else begin
                    count_d[i] = '0;
                end
`endif
            end else if (count_q[i] == '0) begin
                strobe_d[i] = 1'b1;
                count_d[i]  = reload[i];
`ifdef TIMING_STROBE_ONESHOT_EN
                if (oneshot_i[i]) begin
                    armed_d[i] = 1'b0;
                    count_d[i] = '0;
                end
`endif
            end else begin
                count_d[i]  = count_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= DEFAULT_CYCLES;
                count_q[i]  <= DEFAULT_RELOAD;
            end
            strobe_q <= '0;
`ifdef TIMING_STROBE_ONESHOT_EN
            armed_q  <= '1;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
            strobe_q <= strobe_d;
`ifdef TIMING_STROBE_ONESHOT_EN
            armed_q  <= armed_d;
`endif
        end
    end

    assign strobe_o = strobe_q;

endmodule

// File: tb/tb_timing_strobe_gen.sv
// Randomised and directed bench for timing_strobe_gen against an edge-counting reference model.
// The one-shot scenarios are built only when TIMING_STROBE_ONESHOT_EN is defined.
module tb_timing_strobe_gen;

    localparam int CH  = 5;
    localparam int CW  = 16;
    localparam int DEF = 64;
`ifdef TIMING_STROBE_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_i;
    logic [CH-1:0] enable_i;
    logic          sync_i;
    logic          wr_en_i;
    logic [2:0]    wr_chan_i;
    logic [CW-1:0] wr_period_i;
    logic [CH-1:0] oneshot_r;
    logic [CH-1:0] strobe_o;

    int tests_run = 0;
    int failures  = 0;

    // Reference state: programmed period and enabled edges counted since the phase restarted.
    int            m_p [CH];
    int            m_n [CH];
    bit            m_armed [CH];
    logic [CH-1:0] m_strobe;

    timing_strobe_gen #(
        .CHANNELS(CH), .CNT_WIDTH(CW), .DEFAULT_PERIOD_NS(1000), .SYS_CLOCK_MHZ(64)
    ) dut (
        .clock_i(clock),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .sync_i(sync_i),
        .wr_en_i(wr_en_i),
        .wr_chan_i(wr_chan_i),
        .wr_period_i(wr_period_i),
`ifdef TIMING_STROBE_ONESHOT_EN
        .oneshot_i(oneshot_r),
`endif
        .strobe_o(strobe_o)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h, expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelEdge(input logic rst, input logic [CH-1:0] en, input logic sync,
                             input logic wr, input logic [2:0] chan, input logic [CW-1:0] per,
                             input logic [CH-1:0] os);
        for (int i = 0; i < CH; i++) begin
            if (rst) begin
                m_p[i] = DEF; m_n[i] = 0; m_strobe[i] = 1'b0; m_armed[i] = 1'b1;
            end else if ((wr && int'(chan) == i) || sync) begin
                if (wr && int'(chan) == i) m_p[i] = int'(per);
                m_n[i] = 0; m_strobe[i] = 1'b0; m_armed[i] = 1'b1;
            end else if (!en[i]) begin
                m_n[i] = 0; m_strobe[i] = 1'b0; m_armed[i] = 1'b1;
            end else if (m_p[i] == 0) begin
                m_n[i] = 0; m_strobe[i] = 1'b0;
            end else if (ONESHOT && !m_armed[i]) begin
                m_strobe[i] = 1'b0;
                if (!os[i]) begin
                    m_armed[i] = 1'b1; m_n[i] = 0;
                end
            end else begin
                m_n[i] = m_n[i] + 1;
                if (m_n[i] == m_p[i]) begin
                    m_strobe[i] = 1'b1; m_n[i] = 0;
                    if (ONESHOT && os[i]) m_armed[i] = 1'b0;
                end else begin
                    m_strobe[i] = 1'b0;
                end
            end
        end
    endtask

    // One clock edge: drive inputs, advance the model, compare just after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic [CH-1:0] en,
                                 input logic sync, input logic wr, input logic [2:0] chan,
                                 input logic [CW-1:0] per, input logic [CH-1:0] os);
        reset_i = rst; enable_i = en; sync_i = sync;
        wr_en_i = wr; wr_chan_i = chan; wr_period_i = per; oneshot_r = os;
        @(posedge clock);
        modelEdge(rst, en, sync, wr, chan, per, os);
        #1;
        checkOutput(tag, 32'(strobe_o), 32'(m_strobe));
    endtask

    task automatic idle(input string tag, input int n, input logic [CH-1:0] en, input logic [CH-1:0] os);
        for (int k = 0; k < n; k++) applyStimulus(tag, 1'b0, en, 1'b0, 1'b0, 3'd0, '0, os);
    endtask

    localparam logic [CH-1:0] ALL = '1;
    localparam logic [CH-1:0] NONE = '0;

    initial begin
        int  ch0_pulses;
        bit  found;

        for (int i = 0; i < CH; i++) begin
            m_p[i] = DEF; m_n[i] = 0; m_armed[i] = 1'b1;
        end
        m_strobe = '0;

        applyStimulus("reset", 1'b1, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
        applyStimulus("reset", 1'b1, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);

        // Default period: strobes after edges 64, 128, 192.
        ch0_pulses = 0;
        for (int k = 0; k < 195; k++) begin
            applyStimulus("default_period", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
            ch0_pulses += int'(strobe_o[0]);
        end
        checkOutput("default_pulse_count", 32'(ch0_pulses), 32'd3);

        applyStimulus("write_ch1_3", 1'b0, ALL, 1'b0, 1'b1, 3'd1, 16'd3, NONE);
        idle("period_3", 20, ALL, NONE);

        applyStimulus("write_ch2_1", 1'b0, ALL, 1'b0, 1'b1, 3'd2, 16'd1, NONE);
        idle("period_1", 6, ALL, NONE);
        applyStimulus("write_ch2_0", 1'b0, ALL, 1'b0, 1'b1, 3'd2, 16'd0, NONE);
        idle("period_0", 6, ALL, NONE);

        applyStimulus("write_oob", 1'b0, ALL, 1'b0, 1'b1, 3'd7, 16'd2, NONE);
        idle("after_oob", 4, ALL, NONE);

        for (int c = 0; c < CH; c++) begin
            applyStimulus("stagger", 1'b0, ALL, 1'b0, 1'b1, 3'(c), 16'd5, NONE);
            applyStimulus("stagger", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
        end
        idle("staggered", 3, ALL, NONE);
        applyStimulus("sync", 1'b0, ALL, 1'b1, 1'b0, 3'd0, '0, NONE);
        idle("after_sync", 11, ALL, NONE);
        applyStimulus("sync_write", 1'b0, ALL, 1'b1, 1'b1, 3'd0, 16'd2, NONE);
        idle("after_sync_write", 7, ALL, NONE);

        applyStimulus("enable_drop", 1'b0, 5'b11110, 1'b0, 1'b0, 3'd0, '0, NONE);
        idle("reenable", 6, ALL, NONE);

        // Reset exactly on the edge where ch0 is due to strobe.
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (m_p[0] > 0 && m_n[0] == m_p[0] - 1) found = 1'b1;
            else applyStimulus("seek_due", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
        end
        checkOutput("due_found", 32'(found), 32'd1);
        applyStimulus("reset_due", 1'b1, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
        ch0_pulses = 0;
        for (int k = 0; k < 66; k++) begin
            applyStimulus("after_reset", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, NONE);
            ch0_pulses += int'(strobe_o[0]);
        end
        checkOutput("after_reset_pulses", 32'(ch0_pulses), 32'd1);

`ifdef TIMING_STROBE_ONESHOT_EN
        applyStimulus("os_write", 1'b0, ALL, 1'b0, 1'b1, 3'd0, 16'd4, 5'b00001);
        ch0_pulses = 0;
        for (int k = 0; k < 24; k++) begin
            applyStimulus("oneshot", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, 5'b00001);
            ch0_pulses += int'(strobe_o[0]);
        end
        checkOutput("oneshot_count", 32'(ch0_pulses), 32'd1);
        applyStimulus("os_disable", 1'b0, 5'b11110, 1'b0, 1'b0, 3'd0, '0, 5'b00001);
        ch0_pulses = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus("os_rearm", 1'b0, ALL, 1'b0, 1'b0, 3'd0, '0, 5'b00001);
            ch0_pulses += int'(strobe_o[0]);
        end
        checkOutput("oneshot_rearm_count", 32'(ch0_pulses), 32'd1);
        idle("os_release", 12, ALL, NONE);
`endif

        // Random traffic.
        begin
            logic [CH-1:0] en;
            logic [CH-1:0] os;
            os = NONE;
            for (int k = 0; k < 1500; k++) begin
                for (int i = 0; i < CH; i++) en[i] = ($urandom_range(0, 19) != 0);
                if (ONESHOT && $urandom_range(0, 49) == 0) os[$urandom_range(0, CH-1)] ^= 1'b1;
                applyStimulus("random", ($urandom_range(0, 299) == 0), en,
                              ($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
                              3'($urandom_range(0, 7)),
                              ($urandom_range(0, 9) == 0) ? 16'($urandom_range(20, 70))
                                                          : 16'($urandom_range(0, 9)),
                              os);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule

// File: doc/timing_strobe_gen.md
# timing_strobe_gen

Multi-channel programmable clock-enable generator. Replaces hand-coded per-peripheral dividers with one parametrised block that emits single-cycle strobes at programmable periods on the system clock. Reset-time periods are specified in nanoseconds and converted to cycles with the shared `common_pkg::ns_to_cycles`. It sits beside the Wishbone register decode, which reprograms periods at runtime.

## Interface
Parameters:
- `CHANNELS`, 4: number of independent strobe channels (1..16).
- `CNT_WIDTH`, 16: period/counter width in bits.
- `DEFAULT_PERIOD_NS`, 1000: reset period for every channel, in ns. `DEFAULT_CYCLES = ns_to_cycles(DEFAULT_PERIOD_NS)`. Elaboration error if `DEFAULT_CYCLES` is 0 or exceeds 2^CNT_WIDTH-1.

Ports:
- `clock_i`  in  1  system clock (SYS_CLOCK_MHZ).
- `reset_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  CHANNELS  per-channel run enable.
- `sync_i`  in  1  restart the phase of all channels.
- `wr_en_i`  in  1  period write strobe.
- `wr_chan_i`  in  max(1,$clog2(CHANNELS))  channel to write.
- `wr_period_i`  in  CNT_WIDTH  new period in cycles; 0 disables the channel.
- `strobe_o`  out  CHANNELS  registered single-cycle strobes.
- `oneshot_i`  in  CHANNELS  one-shot mode select (only with `TIMING_STROBE_ONESHOT_EN`).

One clock; reset is synchronous and active-high.

## Operation
- Per channel: period register `P`, down-counter `C` (CNT_WIDTH bits each).
- Priority at each edge: reset, then write/sync, then count.
- Count, with channel enabled and `P != 0`:
  - `C == 0`: `strobe_o` <= 1 and `C` <= `P-1`.
  - Otherwise: `C` <= `C-1` and `strobe_o` <= 0.
- Enable low: `C` <= `P-1`; `strobe_o` <= 0.
- `P == 0`: `C` <= 0; `strobe_o` <= 0.
- Write (`wr_en_i` with `wr_chan_i` < CHANNELS):
  - `P` <= `wr_period_i`.
  - `C` <= `wr_period_i-1`, or 0 if `wr_period_i` is 0.
  - That channel's strobe is forced 0 at that edge.
  - An out-of-range `wr_chan_i` is ignored.
- `sync_i`: every channel gets `C` <= `P-1` and its strobe is forced 0.
- Write and sync on the same edge: the written channel uses the new `P`; the others use their existing `P`.
- Counter wrap cannot occur, because `C` is always reloaded from `P-1` and never decremented below 0.

## Timing
- Reset values:
  - `strobe_o` = 0.
  - `P` = `DEFAULT_CYCLES`.
  - `C` = `DEFAULT_CYCLES-1`.
- Number the enabled edges starting at 1 after enable, reset release, write or sync. `strobe_o` is high for exactly one cycle after edges P, 2P, 3P, and so on.
- `P = 1`: `strobe_o` is high continuously, starting one cycle after the first enabled edge.
- Reset mid-period: all state returns to reset values at that edge. Any strobe scheduled for that edge is dropped.
- Enable dropped mid-period: the phase is discarded. Re-enabling restarts a full period of P edges.
- Write to a running channel: the next strobe comes P_new enabled edges after the write edge. No partial period is emitted.
- Latency from `wr_en_i` to the new period taking effect: 1 edge.

## Configuration
- `TIMING_STROBE_ONESHOT_EN` defined:
  - The `oneshot_i` port exists.
  - A channel with `oneshot_i` high emits one strobe, then disarms: `C` holds 0 and `strobe_o` stays 0.
  - A disarmed channel re-arms on a write to that channel, on `sync_i`, or on an enable low-to-high transition.
  - If `oneshot_i` is deasserted while disarmed, the channel re-arms on the next edge with `C` <= `P-1`.
- Not defined:
  - The `oneshot_i` port and the arm flags are absent.
  - All channels are periodic only.

## Test plan
- Reset with defaults (64 MHz, 1000 ns): `DEFAULT_CYCLES` = 64. Set `enable_i` = all ones → every channel strobes after enabled edges 64, 128, 192; each strobe is exactly 1 cycle wide.
- Write ch1 `wr_period_i` = 3 mid-period → ch1 strobes after edges 3, 6, 9 counted from the write edge; other channels keep their phase.
- Write ch2 period = 1 → ch2 strobe is constantly high from the second edge onward. Then write 0 → strobe is low on the following cycle and stays low.
- Channels at P = 5 with staggered phases, pulse `sync_i` → all strobes coincide 5 edges after sync. Sync together with a write of ch0 = 2 → ch0 strobes 2 edges after, the others 5 edges after.
- Assert reset on the edge where a strobe is due → no strobe; `P` returns to 64.
- With `TIMING_STROBE_ONESHOT_EN`, ch0 `oneshot_i` = 1 and P = 4 → exactly one strobe after edge 4, none in the next 20 cycles. Toggle `enable_i` low then high → one more strobe 4 edges later.
